// File: rtl/pe_tile_engine.sv
// -----------------------------------------------------------------------------
// pe_tile_engine
//   Weight-stationary ARRAY_X x ARRAY_Y signed MAC tile with its own control FSM.
//   Weights are loaded serially in row-major order, or kept resident when
//   reuse_w is set. Each activation beat carries one lane per row, and that lane
//   is broadcast across the row's columns. After cfg_k beats the accumulators
//   are drained one at a time over a valid/ready handshake.
//
//   Build option: define PE_SAT_EN to clamp each accumulate to the signed
//   ACC_W range. When it is undefined, accumulation wraps two's-complement.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, cfg_k, reuse_w tile launch (sampled in IDLE), beat depth, weight reuse
//   w_valid/w_ready/w_data  serial weight load stream
//   a_valid/a_ready/a_data  activation stream, lane i at [i*ACT_W +: ACT_W]
//   out_valid/out_ready     result drain handshake
//   out_data/out_idx/out_last  accumulator value, its index, final-result flag
//   busy, done            not-IDLE flag, one-cycle completion pulse
// -----------------------------------------------------------------------------
module pe_tile_engine #(
    parameter int ACT_W   = 16,
    parameter int WGT_W   = 8,
    parameter int ACC_W   = 40,
    parameter int ARRAY_X = 4,
    parameter int ARRAY_Y = 4,
    parameter int K_W     = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [K_W-1:0]                           cfg_k,
    input  logic                                     reuse_w,
    input  logic                                     w_valid,
    output logic                                     w_ready,
    input  logic [WGT_W-1:0]                         w_data,
    input  logic                                     a_valid,
    output logic                                     a_ready,
    input  logic [ARRAY_X*ACT_W-1:0]                 a_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [ACC_W-1:0]                         out_data,
    output logic [$clog2(ARRAY_X*ARRAY_Y)-1:0]       out_idx,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done
);
    localparam int N     = ARRAY_X * ARRAY_Y;
    localparam int IDX_W = $clog2(N);
    localparam int PRD_W = ACT_W + WGT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // S_CLEAR is the COMPUTE entry cycle: accumulators are zeroed and a_ready is held low.
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_CLEAR, S_COMPUTE, S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic [K_W-1:0]          k_reg;
    logic [K_W-1:0]          kcnt;
    logic [IDX_W-1:0]        idx;       // weight write pointer in LOAD_W, result pointer in DRAIN
    logic signed [WGT_W-1:0] w   [N];
    logic signed [ACC_W-1:0] acc [N];

    logic signed [PRD_W-1:0] prod   [N];
    logic signed [ACC_W:0]   sum    [N];
    logic signed [ACC_W-1:0] acc_nx [N];

    // One extra sum bit exposes overflow. The product always fits in ACC_W bits.
    always_comb begin
        for (int unsigned i = 0; i < ARRAY_X; i++) begin
            for (int unsigned j = 0; j < ARRAY_Y; j++) begin
                prod[i*ARRAY_Y+j] = PRD_W'($signed(a_data[i*ACT_W +: ACT_W]))
                                  * PRD_W'(w[i*ARRAY_Y+j]);
                sum[i*ARRAY_Y+j]  = (ACC_W+1)'(acc[i*ARRAY_Y+j])
                                  + (ACC_W+1)'(prod[i*ARRAY_Y+j]);
`ifdef PE_SAT_EN
                if (sum[i*ARRAY_Y+j][ACC_W] != sum[i*ARRAY_Y+j][ACC_W-1])
                    acc_nx[i*ARRAY_Y+j] = sum[i*ARRAY_Y+j][ACC_W]
                                        ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
                else
                    acc_nx[i*ARRAY_Y+j] = sum[i*ARRAY_Y+j][ACC_W-1:0];
`else
                acc_nx[i*ARRAY_Y+j] = sum[i*ARRAY_Y+j][ACC_W-1:0];
`endif
            end
        end
    end

    always_comb begin
        state_nx  = state;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:    if (start) state_nx = reuse_w ? S_CLEAR : S_LOAD_W;
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && idx == LAST_IDX) state_nx = S_CLEAR;
            end
            S_CLEAR:   state_nx = (k_reg == '0) ? S_DRAIN : S_COMPUTE;
            S_COMPUTE: begin
                a_ready = 1'b1;
                if (a_valid && kcnt == k_reg - K_W'(1)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && idx == LAST_IDX) state_nx = S_IDLE;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign out_last = out_valid && (idx == LAST_IDX);
    assign out_idx  = out_valid ? idx : '0;
    assign out_data = out_valid ? acc[idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k_reg <= '0;
            kcnt  <= '0;
            idx   <= '0;
            done  <= 1'b0;
            for (int unsigned n = 0; n < N; n++) begin
                w[n]   <= '0;
                acc[n] <= '0;
            end
        end else begin
            state <= state_nx;
            done  <= (state == S_DRAIN) && out_ready && (idx == LAST_IDX);
            case (state)
                S_IDLE: if (start) begin
                    k_reg <= cfg_k;
                    idx   <= '0;
                end
                S_LOAD_W: if (w_valid) begin
                    w[idx] <= w_data;
                    idx    <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                end
                S_CLEAR: begin
                    kcnt <= '0;
                    idx  <= '0;
                    for (int unsigned n = 0; n < N; n++) acc[n] <= '0;
                end
                S_COMPUTE: if (a_valid) begin
                    kcnt <= kcnt + K_W'(1);
                    for (int unsigned n = 0; n < N; n++) acc[n] <= acc_nx[n];
                end
                S_DRAIN: if (out_ready)
                    idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_tile_engine.sv
module tb_pe_tile_engine;
    localparam int N = 16;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, reuse_w = 1'b0;
    logic        w_valid = 1'b0, a_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] cfg_k = '0;
    logic [7:0]  w_data = '0;
    logic [63:0] a_data = '0;

    logic        w_ready, a_ready, out_valid, out_last, busy, done;
    logic [39:0] out_data;
    logic [3:0]  out_idx;
    logic        w_ready2, a_ready2, out_valid2, out_last2, busy2, done2;
    logic [23:0] out_data2;
    logic [3:0]  out_idx2;

    pe_tile_engine dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .reuse_w(reuse_w),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    // Narrow-accumulator twin driven by the same stimulus, for the wrap/clamp boundary.
    pe_tile_engine #(.ACC_W(24)) dut24 (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .reuse_w(reuse_w),
        .w_valid(w_valid), .w_ready(w_ready2), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready2), .a_data(a_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_idx(out_idx2), .out_last(out_last2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0, done_cnt = 0;
    bit seen_w = 0, seen_a = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [39:0] d40;
        logic [23:0] d24;
        logic        last;
    } exp_t;
    exp_t q[$];

    longint wm[N], m40[N], m24[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint step(input longint a, input longint p, input int w);
        longint s, mx, mn;
        s  = a + p;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
`ifdef PE_SAT_EN
        if (s > mx) s = mx;
        if (s < mn) s = mn;
`else
        s = (s <<< (64 - w)) >>> (64 - w);
`endif
        return s;
    endfunction

    always @(negedge clk) if (!rst) begin
        chk("handshake_onehot", 64'($countones({w_ready, a_ready, out_valid}) <= 1), 64'd1);
        if (w_ready) seen_w = 1;
        if (a_ready) seen_a = 1;
        if (done) done_cnt++;
    end

    task automatic check_idle(input string tag);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_a_ready"}, a_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_out_data24"}, out_data2, 0);
    endtask

    task automatic do_start(input int k, input bit r);
        @(posedge clk); #1;
        start = 1; cfg_k = 16'(k); reuse_w = r;
        @(posedge clk); #1;
        start = 0; reuse_w = 0;
        for (int n = 0; n < N; n++) begin m40[n] = 0; m24[n] = 0; end
    endtask

    task automatic send_w(input int n, input int v);
        int t = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        w_data = 8'(v); w_valid = 1;
        @(negedge clk);
        while (!w_ready && t < 50) begin @(negedge clk); t++; end
        if (!w_ready) chk("w_ready_timeout", 0, 1);
        @(posedge clk); #1;
        w_valid = 0;
        wm[n] = v;
    endtask

    task automatic send_a(input int a0, input int a1, input int a2, input int a3);
        int t = 0;
        longint lane[4];
        lane[0] = longint'(signed'(16'(a0))); lane[1] = longint'(signed'(16'(a1)));
        lane[2] = longint'(signed'(16'(a2))); lane[3] = longint'(signed'(16'(a3)));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        a_data = {16'(a3), 16'(a2), 16'(a1), 16'(a0)}; a_valid = 1;
        @(negedge clk);
        while (!a_ready && t < 50) begin @(negedge clk); t++; end
        if (!a_ready) chk("a_ready_timeout", 0, 1);
        @(posedge clk); #1;
        a_valid = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                m40[i*4+j] = step(m40[i*4+j], lane[i] * wm[i*4+j], 40);
                m24[i*4+j] = step(m24[i*4+j], lane[i] * wm[i*4+j], 24);
            end
    endtask

    task automatic push_exp();
        for (int n = 0; n < N; n++) begin
            exp_t e;
            e.idx = 4'(n); e.d40 = m40[n][39:0]; e.d24 = m24[n][23:0]; e.last = (n == N - 1);
            q.push_back(e);
        end
    endtask

    task automatic drain(input int stall_idx, input int start_at);
        for (int n = 0; n < N; n++) begin
            exp_t e;
            int t = 0;
            @(negedge clk);
            while (!out_valid && t < 100) begin @(negedge clk); t++; end
            chk("out_valid", out_valid, 1);
            if (q.size() == 0) begin chk("queue_underrun", 0, 1); break; end
            e = q.pop_front();
            chk("out_idx", out_idx, e.idx);
            chk("out_data", out_data, e.d40);
            chk("out_data24", out_data2, e.d24);
            chk("out_last", out_last, e.last);
            if (n == stall_idx)
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_idx", out_idx, e.idx);
                    chk("stall_data", out_data, e.d40);
                end
            if (n == start_at) start = 1;
            out_ready = 1;
            @(posedge clk); #1;
            out_ready = 0; start = 0;
        end
        @(negedge clk);
        chk("done_after_last", done, 1);
        chk("busy_after_last", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_stays_idle", busy, 0);
        chk("queue_leftover", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int dc;
        for (int n = 0; n < N; n++) wm[n] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_idle("reset");

        // Tile 1: w[i][j]=i*4+j, three beats of ones -> 3*(i*4+j).
        do_start(3, 0);
        for (int n = 0; n < N; n++) send_w(n, n);
        repeat (3) send_a(1, 1, 1, 1);
        push_exp();
        drain(-1, -1);

        // Weight reuse with identical activations, result stall at idx 7.
        seen_w = 0;
        do_start(3, 1);
        repeat (3) send_a(1, 1, 1, 1);
        push_exp();
        drain(7, -1);
        chk("reuse_no_w_ready", seen_w, 0);

        // Reuse with random signed activations.
        do_start(4, 1);
        repeat (4) send_a($urandom, $urandom, $urandom, $urandom);
        push_exp();
        drain(-1, -1);

        // Stress: -32768 * -128 = 4194304; two beats hit the 24-bit boundary.
        do_start(1, 0);
        for (int n = 0; n < N; n++) send_w(n, -128);
        send_a(-32768, -32768, -32768, -32768);
        push_exp();
        drain(-1, -1);
        do_start(2, 1);
        repeat (2) send_a(-32768, -32768, -32768, -32768);
        push_exp();
        drain(-1, -1);

        // cfg_k=0, with a start pulse during DRAIN that must be ignored.
        seen_a = 0;
        do_start(0, 1);
        push_exp();
        drain(-1, 3);
        chk("k0_no_a_ready", seen_a, 0);

        // Reset mid-COMPUTE aborts the tile and clears the weights.
        do_start(2, 0);
        for (int n = 0; n < N; n++) send_w(n, n + 1);
        send_a(2, 2, 2, 2);
        dc = done_cnt;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_idle("midreset");
        repeat (3) @(negedge clk);
        chk("midreset_no_done", done_cnt, dc);
        for (int n = 0; n < N; n++) wm[n] = 0;
        do_start(2, 1);
        repeat (2) send_a(5, 6, 7, 8);
        push_exp();
        drain(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
